// File: rtl/lt24_layer_compositor.sv
// LT24 frame engine: window-setup command burst, then an upscaled background raster with an optional colour-keyed sprite.
// Build option: define LT24_SPRITE_EN to enable sprite compositing; otherwise every pixel is the background word.
module lt24_layer_compositor #(
  parameter int H_RES       = 240,
  parameter int V_RES       = 320,
  parameter int BG_SCALE    = 4,
  parameter int BG_ADDR_W   = 13,
  parameter int SPR_W       = 64,
  parameter int SPR_H       = 64,
  parameter int SPR_ADDR_W  = 12,
  parameter int WR_LOW_CYC  = 1,
  parameter int WR_HIGH_CYC = 1
) (
  input  logic                  clk_clk,
  input  logic                  reset_reset,
  input  logic                  start,
  input  logic [8:0]            spr_x,
  input  logic [8:0]            spr_y,
  input  logic [15:0]           color_key,
  output logic                  busy,
  output logic                  frame_done,
  output logic [BG_ADDR_W-1:0]  bg_mem_address,
  output logic                  bg_mem_chipselect,
  output logic                  bg_mem_clken,
  input  logic [15:0]           bg_mem_readdata,
  output logic [SPR_ADDR_W-1:0] spr_mem_address,
  output logic                  spr_mem_chipselect,
  output logic                  spr_mem_clken,
  input  logic [15:0]           spr_mem_readdata,
  output logic                  lt24_cs,
  output logic                  lt24_rs,
  output logic                  lt24_rd,
  output logic                  lt24_wr,
  output logic [15:0]           lt24_data
);

  typedef enum logic [1:0] {IDLE, CMD, PIX, DONE} state_t;

  localparam int SLOT_LEN = WR_LOW_CYC + WR_HIGH_CYC;
  localparam int BS_B     = $clog2(BG_SCALE);
  localparam logic [9:0] X_LAST     = 10'(H_RES - 1);
  localparam logic [9:0] Y_LAST     = 10'(V_RES - 1);
  localparam logic [9:0] SCALE_MASK = 10'(BG_SCALE - 1);
  localparam logic [BG_ADDR_W-1:0] BG_W = BG_ADDR_W'(H_RES / BG_SCALE);
  localparam logic [15:0] H_LAST16 = 16'(H_RES - 1);
  localparam logic [15:0] V_LAST16 = 16'(V_RES - 1);

  state_t state_reg, state_next;
  logic [7:0]           slot_cnt_reg;
  logic [3:0]           cmd_idx_reg;
  logic [9:0]           x_reg, y_reg;
  logic [BG_ADDR_W-1:0] row_base_reg;
  logic                 fetch_done_reg;
  logic [15:0]          data_reg;
  logic                 rs_reg;

  logic                 active, slot_end;
  logic [9:0]           x_next, y_next;
  logic [BG_ADDR_W-1:0] row_base_next;
  logic                 fetch_done_next;
  logic [15:0]          pixel_word;

  function automatic logic [15:0] cmd_word(input logic [3:0] idx);
    case (idx)
      4'd0:    return 16'h002A;
      4'd3:    return {8'h00, H_LAST16[15:8]};
      4'd4:    return {8'h00, H_LAST16[7:0]};
      4'd5:    return 16'h002B;
      4'd8:    return {8'h00, V_LAST16[15:8]};
      4'd9:    return {8'h00, V_LAST16[7:0]};
      4'd10:   return 16'h002C;
      default: return 16'h0000;
    endcase
  endfunction

  function automatic logic cmd_rs(input logic [3:0] idx);
    return !(idx == 4'd0 || idx == 4'd5 || idx == 4'd10);
  endfunction

  assign active   = (state_reg == CMD) || (state_reg == PIX);
  assign slot_end = (slot_cnt_reg == 8'(SLOT_LEN - 1));

  always_ff @(posedge clk_clk) begin
    if (reset_reset) state_reg <= IDLE;
    else             state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE: if (start) state_next = CMD;
      CMD:  if (slot_end && cmd_idx_reg == 4'd10) state_next = PIX;
      PIX:  if (slot_end && fetch_done_reg) state_next = DONE;
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Raster advance of the fetch position; the row base steps by BG_W every BG_SCALE lines.
  always_comb begin
    x_next          = x_reg + 10'd1;
    y_next          = y_reg;
    row_base_next   = row_base_reg;
    fetch_done_next = 1'b0;
    if (x_reg == X_LAST) begin
      if (y_reg == Y_LAST) begin
        x_next          = x_reg;
        fetch_done_next = 1'b1;
      end else begin
        x_next = 10'd0;
        y_next = y_reg + 10'd1;
        if (((y_reg + 10'd1) & SCALE_MASK) == 10'd0) row_base_next = row_base_reg + BG_W;
      end
    end
  end

  // Addresses track the fetch position, which runs one pixel ahead of the bus slot.
  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      slot_cnt_reg   <= 8'd0;
      cmd_idx_reg    <= 4'd0;
      x_reg          <= 10'd0;
      y_reg          <= 10'd0;
      row_base_reg   <= '0;
      fetch_done_reg <= 1'b0;
      data_reg       <= 16'h0000;
      rs_reg         <= 1'b1;
    end else begin
      case (state_reg)
        IDLE: begin
          if (start) begin
            slot_cnt_reg   <= 8'd0;
            cmd_idx_reg    <= 4'd0;
            x_reg          <= 10'd0;
            y_reg          <= 10'd0;
            row_base_reg   <= '0;
            fetch_done_reg <= 1'b0;
            data_reg       <= cmd_word(4'd0);
            rs_reg         <= cmd_rs(4'd0);
          end
        end
        CMD: begin
          if (slot_end) begin
            slot_cnt_reg <= 8'd0;
            if (cmd_idx_reg == 4'd10) begin
              data_reg       <= pixel_word;
              rs_reg         <= 1'b1;
              x_reg          <= x_next;
              y_reg          <= y_next;
              row_base_reg   <= row_base_next;
              fetch_done_reg <= fetch_done_next;
            end else begin
              cmd_idx_reg <= cmd_idx_reg + 4'd1;
              data_reg    <= cmd_word(cmd_idx_reg + 4'd1);
              rs_reg      <= cmd_rs(cmd_idx_reg + 4'd1);
            end
          end else begin
            slot_cnt_reg <= slot_cnt_reg + 8'd1;
          end
        end
        PIX: begin
          if (slot_end) begin
            slot_cnt_reg <= 8'd0;
            if (!fetch_done_reg) begin
              data_reg       <= pixel_word;
              x_reg          <= x_next;
              y_reg          <= y_next;
              row_base_reg   <= row_base_next;
              fetch_done_reg <= fetch_done_next;
            end
          end else begin
            slot_cnt_reg <= slot_cnt_reg + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bg_mem_address    = row_base_reg + BG_ADDR_W'(x_reg >> BS_B);
  assign bg_mem_chipselect = active;
  assign bg_mem_clken      = active;

`ifdef LT24_SPRITE_EN
  localparam int SW_B = $clog2(SPR_W);
  localparam int DY_W = SPR_ADDR_W - SW_B;

  logic [9:0]      sx_reg, sy_reg;
  logic [15:0]     key_reg;
  logic            spr_hit;
  logic [SW_B-1:0] dx;
  logic [DY_W-1:0] dy;

  always_ff @(posedge clk_clk) begin
    if (reset_reset) begin
      sx_reg  <= 10'd0;
      sy_reg  <= 10'd0;
      key_reg <= 16'h0000;
    end else if (state_reg == IDLE && start) begin
      sx_reg  <= {1'b0, spr_x};
      sy_reg  <= {1'b0, spr_y};
      key_reg <= color_key;
    end
  end

  // 10-bit compares: spr_x + SPR_W never wraps, so off-screen parts simply never hit.
  assign spr_hit = (x_reg >= sx_reg) && (x_reg < sx_reg + 10'(SPR_W)) &&
                   (y_reg >= sy_reg) && (y_reg < sy_reg + 10'(SPR_H));
  assign dx = SW_B'(x_reg - sx_reg);
  assign dy = DY_W'(y_reg - sy_reg);

  assign spr_mem_address    = {dy, dx};
  assign spr_mem_chipselect = active;
  assign spr_mem_clken      = active;
  assign pixel_word = (spr_hit && spr_mem_readdata != key_reg) ? spr_mem_readdata : bg_mem_readdata;
`else
  logic unused_sprite;
  assign unused_sprite      = ^{spr_x, spr_y, color_key, spr_mem_readdata};
  assign spr_mem_address    = '0;
  assign spr_mem_chipselect = 1'b0;
  assign spr_mem_clken      = 1'b0;
  assign pixel_word         = bg_mem_readdata;
`endif

  assign busy       = active;
  assign frame_done = (state_reg == DONE);
  assign lt24_cs    = !active;
  assign lt24_rd    = 1'b1;
  assign lt24_wr    = active ? (slot_cnt_reg >= 8'(WR_LOW_CYC)) : 1'b1;
  assign lt24_rs    = rs_reg;
  assign lt24_data  = data_reg;

endmodule

// File: tb/tb_lt24_layer_compositor.sv
// Scoreboard bench for lt24_layer_compositor: expected bus words are queued at start, a monitor pops them on each wr fall.
module tb_lt24_layer_compositor;
  localparam int H = 8;
  localparam int V = 4;
`ifdef LT24_SPRITE_EN
  localparam bit SPR_ON = 1'b1;
`else
  localparam bit SPR_ON = 1'b0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, start, start2;
  logic [8:0]  spr_x, spr_y;
  logic [15:0] key;

  logic        busy, fd, bg_cs, bg_ck, spr_cs, spr_ck, cs, rs, rd, wr;
  logic [12:0] bg_addr;
  logic [11:0] spr_addr;
  logic [15:0] bg_rd, spr_rd, data;

  logic        busy2, fd2, bg_cs2, bg_ck2, spr_cs2, spr_ck2, cs2, rs2, rd2, wr2;
  logic [12:0] bg_addr2;
  logic [11:0] spr_addr2;
  logic [15:0] bg_rd2, spr_rd2, data2;

  lt24_layer_compositor #(.H_RES(H), .V_RES(V), .BG_SCALE(2), .BG_ADDR_W(13), .SPR_W(4), .SPR_H(2),
    .SPR_ADDR_W(12), .WR_LOW_CYC(1), .WR_HIGH_CYC(1)) dut (
    .clk_clk(clk), .reset_reset(reset), .start(start), .spr_x(spr_x), .spr_y(spr_y), .color_key(key),
    .busy(busy), .frame_done(fd), .bg_mem_address(bg_addr), .bg_mem_chipselect(bg_cs), .bg_mem_clken(bg_ck),
    .bg_mem_readdata(bg_rd), .spr_mem_address(spr_addr), .spr_mem_chipselect(spr_cs), .spr_mem_clken(spr_ck),
    .spr_mem_readdata(spr_rd), .lt24_cs(cs), .lt24_rs(rs), .lt24_rd(rd), .lt24_wr(wr), .lt24_data(data));

  lt24_layer_compositor #(.H_RES(H), .V_RES(V), .BG_SCALE(2), .BG_ADDR_W(13), .SPR_W(4), .SPR_H(2),
    .SPR_ADDR_W(12), .WR_LOW_CYC(2), .WR_HIGH_CYC(3)) dut2 (
    .clk_clk(clk), .reset_reset(reset), .start(start2), .spr_x(spr_x), .spr_y(spr_y), .color_key(key),
    .busy(busy2), .frame_done(fd2), .bg_mem_address(bg_addr2), .bg_mem_chipselect(bg_cs2), .bg_mem_clken(bg_ck2),
    .bg_mem_readdata(bg_rd2), .spr_mem_address(spr_addr2), .spr_mem_chipselect(spr_cs2), .spr_mem_clken(spr_ck2),
    .spr_mem_readdata(spr_rd2), .lt24_cs(cs2), .lt24_rs(rs2), .lt24_rd(rd2), .lt24_wr(wr2), .lt24_data(data2));

  // Memory models: bg[i]=0x1000+i, sprite all 0xF800 except word 5.
  always_ff @(posedge clk) begin
    if (bg_ck)   bg_rd   <= 16'h1000 + 16'(bg_addr);
    if (spr_ck)  spr_rd  <= (spr_addr == 12'd5) ? 16'hF81F : 16'hF800;
    if (bg_ck2)  bg_rd2  <= 16'h1000 + 16'(bg_addr2);
    if (spr_ck2) spr_rd2 <= (spr_addr2 == 12'd5) ? 16'hF81F : 16'hF800;
  end

  int total = 0;
  int bad = 0;
  int fd_cnt = 0;
  int widx = 0;
  logic prev_wr = 1'b1;
  logic [16:0] exp_q[$];
  logic [15:0] cap[64];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", name, got, want);
    end
  endtask

  // Monitor: one bus write per wr falling edge.
  always @(negedge clk) begin
    logic [16:0] e;
    if (!wr && prev_wr) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_write got=%b/%h want=none", rs, data);
      end else begin
        e = exp_q.pop_front();
        if ({rs, data} !== e || cs !== 1'b0) begin
          bad++;
          $display("FAIL word%0d got=%b/%h cs=%b want=%b/%h cs=0", widx, rs, data, cs, e[16], e[15:0]);
        end else
          $display("write %0d rs=%b data=%h", widx, rs, data);
      end
      if (widx < 64) cap[widx] = data;
      widx++;
    end
    if (fd) begin
      fd_cnt++;
      total++;
      if (busy !== 1'b0 || cs !== 1'b1) begin
        bad++;
        $display("FAIL done_state got busy=%b cs=%b want busy=0 cs=1", busy, cs);
      end
    end
    prev_wr = wr;
  end

  task automatic push_frame(input int sx, input int sy, input logic [15:0] k);
    logic [15:0] cmd_tab[11] = '{16'h2A, 16'h00, 16'h00, 16'h00, 16'h07, 16'h2B, 16'h00, 16'h00, 16'h00, 16'h03, 16'h2C};
    logic        rs_tab[11]  = '{1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    logic [15:0] px, sw;
    for (int i = 0; i < 11; i++) exp_q.push_back({rs_tab[i], cmd_tab[i]});
    for (int y = 0; y < V; y++)
      for (int x = 0; x < H; x++) begin
        px = 16'h1000 + 16'((y / 2) * 4 + x / 2);
        if (SPR_ON && x >= sx && x < sx + 4 && y >= sy && y < sy + 2) begin
          sw = (((y - sy) * 4 + (x - sx)) == 5) ? 16'hF81F : 16'hF800;
          if (sw != k) px = sw;
        end
        exp_q.push_back({1'b1, px});
      end
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic wait_frame(input int budget);
    int f0 = fd_cnt;
    for (int c = 0; c < budget && fd_cnt == f0; c++) @(negedge clk);
    check("frame_done_seen", 32'(fd_cnt != f0), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run_frame(input int sx, input int sy, input logic [15:0] k);
    spr_x = 9'(sx); spr_y = 9'(sy); key = k;
    widx = 0;
    push_frame(sx, sy, k);
    pulse_start();
    wait_frame(400);
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    check("writes_per_frame", 32'(widx), 32'd43);
  endtask

  function automatic int pix(input int x, input int y);
    return 11 + y * H + x;
  endfunction

  task automatic test_slow_bus();
    int lo_run = 0, hi_run = 0, slots = 0, bad_lo = 0, bad_hi = 0, unstable = 0;
    logic [15:0] d = 16'h0;
    logic pw = 1'b1, done = 1'b0;
    @(posedge clk); #1 start2 = 1'b1;
    @(posedge clk); #1 start2 = 1'b0;
    for (int c = 0; c < 1000 && !done; c++) begin
      @(negedge clk);
      if (!wr2) begin
        if (pw) begin
          if (slots > 0 && hi_run != 3) bad_hi++;
          slots++;
          lo_run = 0;
          d = data2;
        end
        lo_run++;
        if (data2 !== d) unstable++;
      end else if (busy2) begin
        if (!pw) begin
          if (lo_run != 2) bad_lo++;
          hi_run = 0;
        end
        hi_run++;
        if (data2 !== d) unstable++;
      end
      pw = wr2;
      if (fd2) done = 1'b1;
    end
    $display("slow bus frame: slots=%0d last_high=%0d", slots, hi_run);
    check("slow_done_seen", 32'(done), 32'd1);
    check("slow_slot_count", 32'(slots), 32'd43);
    check("slow_low_runs_bad", 32'(bad_lo), 32'd0);
    check("slow_high_runs_bad", 32'(bad_hi + ((hi_run != 3) ? 1 : 0)), 32'd0);
    check("slow_data_unstable", 32'(unstable), 32'd0);
    check("slow_cs_idle", 32'(cs2), 32'd1);
  endtask

  initial begin
    int f0;
    reset = 1'b1; start = 1'b0; start2 = 1'b0;
    spr_x = 9'd200; spr_y = 9'd0; key = 16'hF81F;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cs", 32'(cs), 32'd1);
    check("rst_wr", 32'(wr), 32'd1);
    check("rst_rd", 32'(rd), 32'd1);
    check("rst_rs", 32'(rs), 32'd1);
    check("rst_data", 32'(data), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(fd), 32'd0);
    check("rst_chipselects", 32'({bg_cs, spr_cs, bg_ck, spr_ck}), 32'd0);
    check("rst_addresses", 32'({bg_addr, spr_addr}), 32'd0);
    @(posedge clk); #1 reset = 1'b0;

    // Sprite off-screen: background only.
    run_frame(200, 0, 16'hF81F);
    check("cmd_first", 32'(cap[0]), 32'h2A);
    check("cmd_last", 32'(cap[10]), 32'h2C);
    check("bg_0_0", 32'(cap[pix(0, 0)]), 32'h1000);
    check("bg_7_0", 32'(cap[pix(7, 0)]), 32'h1003);
    check("bg_5_2", 32'(cap[pix(5, 2)]), 32'h1006);
    check("bg_7_3", 32'(cap[pix(7, 3)]), 32'h1007);
    check("busy_after", 32'(busy), 32'd0);

    // Sprite at (2,1) with keyed word 5.
    run_frame(2, 1, 16'hF81F);
    check("spr_2_1", 32'(cap[pix(2, 1)]), SPR_ON ? 32'hF800 : 32'h1001);
    check("spr_5_2", 32'(cap[pix(5, 2)]), SPR_ON ? 32'hF800 : 32'h1006);
    check("spr_key_3_2", 32'(cap[pix(3, 2)]), 32'h1005);
    check("spr_out_6_1", 32'(cap[pix(6, 1)]), 32'h1003);

    // Sprite clipped at the bottom-right corner.
    run_frame(6, 3, 16'hF81F);
    check("clip_6_3", 32'(cap[pix(6, 3)]), SPR_ON ? 32'hF800 : 32'h1007);
    check("clip_7_3", 32'(cap[pix(7, 3)]), SPR_ON ? 32'hF800 : 32'h1007);
    check("clip_5_3", 32'(cap[pix(5, 3)]), 32'h1006);
    check("clip_6_2", 32'(cap[pix(6, 2)]), 32'h1007);

    // Start pulses while busy are ignored.
    spr_x = 9'd200; spr_y = 9'd0;
    widx = 0;
    f0 = fd_cnt;
    push_frame(200, 0, 16'hF81F);
    pulse_start();
    repeat (10) @(posedge clk);
    pulse_start();
    repeat (20) @(posedge clk);
    pulse_start();
    repeat (150) @(posedge clk);
    #1;
    check("single_done", 32'(fd_cnt - f0), 32'd1);
    check("busy_start_queue", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of the pixel phase.
    widx = 0;
    push_frame(200, 0, 16'hF81F);
    pulse_start();
    for (int c = 0; c < 300 && widx < 16; c++) @(negedge clk);
    check("pix_phase_reached", 32'(widx >= 16), 32'd1);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort_cs", 32'(cs), 32'd1);
    check("abort_wr", 32'(wr), 32'd1);
    check("abort_busy", 32'(busy), 32'd0);
    @(posedge clk); #1 reset = 1'b0;
    exp_q.delete();
    run_frame(200, 0, 16'hF81F);
    check("restart_first", 32'(cap[0]), 32'h2A);

    test_slow_bus();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
